// File: rtl/console_pkg.sv
// Shared definitions for the collect-console send arbiter: one-hot FSM state
// encoding, error counter width, default engine timeout and a modular index helper.
package console_pkg;

    localparam int ARB_ERR_W       = 8;
    localparam int ARB_DEF_TIMEOUT = 16'hFFFF;

    // One-hot state encoding; each state owns exactly one bit of the register.
    typedef enum logic [4:0] {
        ARB_IDLE = 5'b00001,
        ARB_PICK = 5'b00010,
        ARB_SEND = 5'b00100,
        ARB_ABRT = 5'b01000,
        ARB_DONE = 5'b10000
    } arb_state_e;

    // (base + off) mod n, for base < n and off < n.
    // The wrap is at n, so requester counts that are not a power of two work.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: finds the first set request at or after ptr,
// wrapping at NUM_REQ.
module rr_pick
    import console_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    int                 off;

    // Rotate so ptr lands on bit 0, then priority-encode the lowest set bit.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        rot = '0;
        off = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot[j] = req[wrap_add(int'(ptr), j, NUM_REQ)];
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
    end

    // Un-rotate the winning offset back to an absolute requester index.
    assign idx = IDX_W'(wrap_add(int'(ptr), off, NUM_REQ));
    assign any = |req;

endmodule

// File: rtl/send_arbiter.sv
// Round-robin arbiter that shares one send engine between NUM_REQ capture sources.
// Sources and engine both use the fs/fd four-phase handshake. A hung engine
// transaction is aborted after TIMEOUT cycles in SEND.
module send_arbiter
    import console_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = ARB_DEF_TIMEOUT,
    parameter int TO_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   fs_req,
    output logic [NUM_REQ-1:0]   fd_req,
    output logic                 fs_send,
    input  logic                 fd_send,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_vld,
    output logic                 err_timeout,
    output logic [ARB_ERR_W-1:0] err_cnt
);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [ARB_ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (fs_req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and next-register logic; everything holds unless a state changes it.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        to_cnt_d    = to_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (|fs_req) state_d = ARB_PICK;
            end
            ARB_PICK: begin
                // Requests may all vanish in this cycle; then grant_idx keeps its old value.
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    to_cnt_d    = '0;
                    state_d     = ARB_SEND;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SEND: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A done on the timeout cycle still counts as a normal completion.
                if (fd_send) begin
                    state_d = ARB_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ARB_ABRT;
                end
            end
            ARB_ABRT: begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                state_d = ARB_DONE;
            end
            ARB_DONE: begin
                // Release only after both the granted source and the engine have dropped.
                if (!fs_req[grant_idx_q] && !fd_send) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Per-source done flag: only the granted source ever sees fd_req, and only in DONE.
    always_comb begin
        fd_req = '0;
        if (state_q == ARB_DONE) fd_req[grant_idx_q] = 1'b1;
    end

    assign fs_send     = (state_q == ARB_SEND);
    assign grant_vld   = (state_q == ARB_PICK) || (state_q == ARB_SEND) ||
                         (state_q == ARB_ABRT) || (state_q == ARB_DONE);
    assign err_timeout = (state_q == ARB_ABRT);
    assign grant_idx   = grant_idx_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_send_arbiter.sv
// Directed bench for send_arbiter: a 4-source instance and a 3-source instance,
// both with TIMEOUT=8. Inputs change 1 time unit after a rising edge; outputs
// are checked at the same point, well away from the next edge.
module tb_send_arbiter;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] fs_req4, fd_req4;
    logic       fs_send4, fd_send4, gvld4, errto4;
    logic [1:0] gidx4;
    logic [7:0] errcnt4;

    logic [2:0] fs_req3, fd_req3;
    logic       fs_send3, fd_send3, gvld3, errto3;
    logic [1:0] gidx3;
    logic [7:0] errcnt3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    send_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(8), .TO_W(16)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .fs_req      (fs_req4),
        .fd_req      (fd_req4),
        .fs_send     (fs_send4),
        .fd_send     (fd_send4),
        .grant_idx   (gidx4),
        .grant_vld   (gvld4),
        .err_timeout (errto4),
        .err_cnt     (errcnt4)
    );

    send_arbiter #(.NUM_REQ(3), .IDX_W(2), .TIMEOUT(8), .TO_W(16)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .fs_req      (fs_req3),
        .fd_req      (fd_req3),
        .fs_send     (fs_send3),
        .fd_send     (fd_send3),
        .grant_idx   (gidx3),
        .grant_vld   (gvld3),
        .err_timeout (errto3),
        .err_cnt     (errcnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full grant on the 4-source DUT, engine answering on its first SEND cycle.
    // Entered in an IDLE cycle with fs_req4 driven; leaves in IDLE with the granted bit dropped.
    task automatic grant4(input string tag, input logic [1:0] exp_idx);
        tick();
        check({tag, "_pick_vld"}, gvld4, 1);
        check({tag, "_pick_fs"}, fs_send4, 0);
        tick();
        check({tag, "_idx"}, gidx4, exp_idx);
        check({tag, "_fs_send"}, fs_send4, 1);
        check({tag, "_fd_req_send"}, fd_req4, 0);
        fd_send4 = 1'b1;
        tick();
        check({tag, "_fd_req_done"}, fd_req4, 4'b0001 << exp_idx);
        fd_send4 = 1'b0;
        fs_req4[exp_idx] = 1'b0;
        tick();
        check({tag, "_idle"}, gvld4, 0);
    endtask

    // One engine timeout on the 4-source DUT using source 1.
    task automatic abort_once(input bit chk, input logic [7:0] exp_cnt);
        fs_req4 = 4'b0010;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            if (chk) check("t4_send_cycle", fs_send4, 1);
            tick();
        end
        if (chk) begin
            check("t4_pulse", errto4, 1);
            check("t4_abrt_fs", fs_send4, 0);
        end
        tick();
        if (chk) begin
            check("t4_pulse_end", errto4, 0);
            check("t4_err_cnt", errcnt4, exp_cnt);
            check("t4_fd_req", fd_req4, 4'b0010);
        end
        fs_req4 = 4'b0000;
        tick();
        if (chk) check("t4_idle", gvld4, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        fs_req4  = '0;
        fd_send4 = 1'b0;
        fs_req3  = '0;
        fd_send3 = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state.
        check("rst_gvld", gvld4, 0);
        check("rst_gidx", gidx4, 0);
        check("rst_errcnt", errcnt4, 0);
        check("rst_fs_send", fs_send4, 0);
        check("rst_fd_req", fd_req4, 0);

        // Single request from source 2, engine answers after five SEND cycles.
        fs_req4 = 4'b0100;
        tick();
        check("t2_pick_vld", gvld4, 1);
        check("t2_pick_fs", fs_send4, 0);
        tick();
        check("t2_fs_send_c2", fs_send4, 1);
        check("t2_gidx", gidx4, 2);
        repeat (4) begin
            tick();
            check("t2_fs_hold", fs_send4, 1);
        end
        fd_send4 = 1'b1;
        tick();
        check("t2_fd_req", fd_req4, 4'b0100);
        check("t2_fs_drop", fs_send4, 0);
        fd_send4 = 1'b0;
        tick();
        check("t2_fd_req_hold", fd_req4, 4'b0100);
        fs_req4 = 4'b0000;
        tick();
        check("t2_idle", gvld4, 0);
        check("t2_fd_req_clr", fd_req4, 0);
        check("t2_gidx_hold", gidx4, 2);
        // Pointer moved to 3, so with everyone asking source 3 wins next.
        fs_req4 = 4'b1111;
        grant4("t2_ptr", 2'd3);

        // All four requesting continuously: strict rotation starting from 0.
        for (int i = 0; i < 5; i++) begin
            fs_req4 = 4'b1111;
            grant4("t3_rr", rr_exp[i]);
        end

        // Done arrives on the exact timeout cycle: completes without error.
        fs_req4 = 4'b0100;
        tick();
        tick();
        repeat (7) tick();
        check("t5_still_send", fs_send4, 1);
        check("t5_no_err_yet", errto4, 0);
        fd_send4 = 1'b1;
        tick();
        check("t5_errto", errto4, 0);
        check("t5_done_fd_req", fd_req4, 4'b0100);
        check("t5_errcnt", errcnt4, 0);
        fd_send4 = 1'b0;
        fs_req4  = 4'b0000;
        tick();
        check("t5_idle", gvld4, 0);
        check("t5_errcnt_after", errcnt4, 0);

        // Engine never answers: abort, then saturation of the error count.
        abort_once(1'b1, 8'd1);
        abort_once(1'b1, 8'd2);
        for (int i = 3; i < 256; i++) abort_once(1'b0, 8'd0);
        abort_once(1'b1, 8'hFF);
        abort_once(1'b1, 8'hFF);

        // Three sources: pointer wraps from 2 to 0, never to a nonexistent index 3.
        fs_req3 = 3'b100;
        tick();
        tick();
        check("t6_first_gidx", gidx3, 2);
        fd_send3 = 1'b1;
        tick();
        check("t6_first_fd_req", fd_req3, 3'b100);
        fd_send3 = 1'b0;
        fs_req3  = 3'b001;
        tick();
        check("t6_idle", gvld3, 0);
        fs_req3 = 3'b101;
        tick();
        tick();
        check("t6_wrap_gidx", gidx3, 0);
        check("t6_wrap_fd_req_send", fd_req3, 0);
        fd_send3 = 1'b1;
        tick();
        check("t6_wrap_fd_req", fd_req3, 3'b001);
        fd_send3 = 1'b0;
        fs_req3  = 3'b100;
        tick();
        fs_req3 = 3'b101;
        tick();
        tick();
        check("t6_next_gidx", gidx3, 2);
        fd_send3 = 1'b1;
        tick();
        check("t6_next_fd_req", fd_req3, 3'b100);
        fd_send3 = 1'b0;
        fs_req3  = 3'b000;
        tick();
        check("t6_end_idle", gvld3, 0);

        // Reset while the engine is busy: everything returns to its reset value.
        fs_req4 = 4'b1000;
        tick();
        tick();
        check("t1_pre_fs_send", fs_send4, 1);
        check("t1_pre_gidx", gidx4, 3);
        rst     = 1'b0;
        fs_req4 = 4'b0000;
        tick();
        rst = 1'b1;
        check("t1_gvld", gvld4, 0);
        check("t1_fs_send", fs_send4, 0);
        check("t1_fd_req", fd_req4, 0);
        check("t1_errcnt", errcnt4, 0);
        check("t1_gidx", gidx4, 0);
        check("t1_errto", errto4, 0);
        // Pointer is back at 0 as well.
        fs_req4 = 4'b1111;
        tick();
        tick();
        check("t1_ptr_gidx", gidx4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
